// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: FSM state encoding and
// default parameter values used by the top and the per-port mux.
package hazard_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 2;
  localparam int unsigned DEF_NUM_RD   = 2;
  localparam int unsigned DEF_NUM_SRC  = 3;
  localparam int unsigned DEF_ZERO_REG = 0;
  localparam int unsigned DEF_CNT_W    = 16;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/fwd_port_mux.sv
// Per-read-port operand select: youngest matching source, then the hold
// entry, then register file data. Also flags a load-use hazard when the
// winning source has no valid data yet.
//   i_rd_addr/i_rd_data          : ID read address and register file data
//   i_src_*                      : packed per-source data/addr/we/ready
//   i_hold_valid/addr/data       : registered copy of the oldest source
//   o_fw_data_c                  : forwarded operand (combinational)
//   o_hazard_c                   : winner exists but is not ready
module fwd_port_mux
  import hazard_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic [ADDR_W-1:0]         i_rd_addr,
  input  logic [DATA_W-1:0]         i_rd_data,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic [NUM_SRC*ADDR_W-1:0] i_src_addr,
  input  logic [NUM_SRC-1:0]        i_src_we,
  input  logic [NUM_SRC-1:0]        i_src_ready,
  input  logic                      i_hold_valid,
  input  logic [ADDR_W-1:0]         i_hold_addr,
  input  logic [DATA_W-1:0]         i_hold_data,
  output logic [DATA_W-1:0]         o_fw_data_c,
  output logic                      o_hazard_c
);

  logic w_hit;
  logic w_ready;

  // Priority select; the first (lowest-index) match locks out older sources.
  always_comb begin
    w_hit       = 1'b0;
    w_ready     = 1'b1;
    o_fw_data_c = i_rd_data;
    if (i_hold_valid && (i_rd_addr == i_hold_addr)) begin
      o_fw_data_c = i_hold_data;
    end
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (!w_hit && i_src_we[s] && (i_rd_addr == i_src_addr[s*ADDR_W +: ADDR_W])) begin
        w_hit       = 1'b1;
        w_ready     = i_src_ready[s];
        o_fw_data_c = i_src_data[s*DATA_W +: DATA_W];
      end
    end
    // Hardwired zero register: never forwarded, never a hazard.
    if ((ZERO_REG != 0) && (i_rd_addr == '0)) begin
      w_hit       = 1'b0;
      o_fw_data_c = '0;
    end
  end

  assign o_hazard_c = w_hit & ~w_ready;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding and pipeline hazard control.
//   clk, rst_n            : clock, async active-low reset
//   src_data/addr/we/ready: forward sources, index 0 youngest (EX)
//   rd_addr/rd_en/rd_data : ID read ports and register file data
//   mem_busy              : multi-cycle data memory access pending
//   cnt_clr               : synchronous stall counter clear
//   fw_data               : forwarded operands (combinational)
//   stall, bubble         : pipeline control (combinational)
//   stall_cnt             : saturating count of stalled cycles
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_we,
  input  logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*DATA_W-1:0]  rd_data,
  input  logic                      mem_busy,
  input  logic                      cnt_clr,
  output logic [NUM_RD*DATA_W-1:0]  fw_data,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned OLD = NUM_SRC - 1;

  fsm_state_e        r_state;
  logic              r_hold_valid;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [NUM_RD-1:0] w_hazard;
  logic              w_load_use;

  // One priority mux per read port.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_SRC (NUM_SRC),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .i_rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .i_rd_data   (rd_data[p*DATA_W +: DATA_W]),
      .i_src_data  (src_data),
      .i_src_addr  (src_addr),
      .i_src_we    (src_we),
      .i_src_ready (src_ready),
      .i_hold_valid(r_hold_valid),
      .i_hold_addr (r_hold_addr),
      .i_hold_data (r_hold_data),
      .o_fw_data_c (fw_data[p*DATA_W +: DATA_W]),
      .o_hazard_c  (w_hazard[p])
    );
  end

  // Only ports actually in use can cause a load-use stall.
  assign w_load_use = |(w_hazard & rd_en);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (mem_busy)  r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (!mem_busy) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall/bubble decode; load-use is ignored while memory already stalls.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          stall  = w_load_use;
          bubble = w_load_use;
        end
        ST_MEM_WAIT: stall = 1'b1;
        default: ;
      endcase
    end
  end

  // Hold entry: one-cycle copy of the oldest source, frozen during MEM_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
    end else if (r_state == ST_IDLE) begin
      r_hold_valid <= src_we[OLD];
      if (src_we[OLD]) begin
        r_hold_addr <= src_addr[OLD*ADDR_W +: ADDR_W];
        r_hold_data <= src_data[OLD*DATA_W +: DATA_W];
      end
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst_n;
  logic [23:0] src_data;
  logic [5:0]  src_addr;
  logic [2:0]  src_we;
  logic [2:0]  src_ready;
  logic [3:0]  rd_addr;
  logic [1:0]  rd_en;
  logic [15:0] rd_data;
  logic        mem_busy;
  logic        cnt_clr;

  logic [15:0] fw_data, z_fw_data, s_fw_data;
  logic        stall, z_stall, s_stall;
  logic        bubble, z_bubble, s_bubble;
  logic [15:0] stall_cnt, z_stall_cnt;
  logic [2:0]  s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_addr(src_addr),
    .src_we(src_we), .src_ready(src_ready), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .fw_data(fw_data), .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  hazard_forward_unit #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_addr(src_addr),
    .src_we(src_we), .src_ready(src_ready), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .fw_data(z_fw_data), .stall(z_stall), .bubble(z_bubble), .stall_cnt(z_stall_cnt)
  );

  hazard_forward_unit #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_addr(src_addr),
    .src_we(src_we), .src_ready(src_ready), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .fw_data(s_fw_data), .stall(s_stall), .bubble(s_bubble), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d0, d1, d2;
    logic [1:0] a0, a1, a2;
    logic [2:0] we, rdy;
    logic [1:0] p0, p1, en;
    logic [7:0] rf0, rf1, f0, f1;
    logic       st, bb;
  } vec_t;

  function automatic vec_t mk(
    input logic [7:0] d0, d1, d2, input logic [1:0] a0, a1, a2,
    input logic [2:0] we, rdy, input logic [1:0] p0, p1, en,
    input logic [7:0] rf0, rf1, f0, f1, input logic st, bb);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.we = we; v.rdy = rdy; v.p0 = p0; v.p1 = p1; v.en = en;
    v.rf0 = rf0; v.rf1 = rf1; v.f0 = f0; v.f1 = f1; v.st = st; v.bb = bb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    src_data  = '0;
    src_addr  = '0;
    src_we    = '0;
    src_ready = '1;
    rd_addr   = '0;
    rd_en     = '0;
    rd_data   = '0;
    mem_busy  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000, 3'b111, 1, 2, 2'b11, 8'hA1, 8'hB2, 8'hA1, 8'hB2, 0, 0);
    vecs[1]  = mk(8'h11, 8'h22, 8'h00, 1, 1, 0, 3'b011, 3'b111, 1, 3, 2'b11, 8'hA1, 8'hB3, 8'h11, 8'hB3, 0, 0);
    vecs[2]  = mk(8'h44, 8'h33, 8'h00, 3, 2, 0, 3'b011, 3'b111, 2, 3, 2'b11, 8'hC2, 8'hC3, 8'h33, 8'h44, 0, 0);
    vecs[3]  = mk(8'h66, 8'h55, 8'h00, 2, 2, 0, 3'b011, 3'b101, 2, 0, 2'b11, 8'hC4, 8'h07, 8'h66, 8'h07, 0, 0);
    vecs[4]  = mk(8'h00, 8'h77, 8'h00, 0, 1, 0, 3'b010, 3'b101, 0, 1, 2'b01, 8'h09, 8'hD5, 8'h09, 8'h77, 0, 0);
    vecs[5]  = mk(8'h00, 8'h77, 8'h00, 0, 1, 0, 3'b010, 3'b101, 0, 1, 2'b11, 8'h09, 8'hD5, 8'h09, 8'h77, 1, 1);
    vecs[6]  = mk(8'h00, 8'h00, 8'h88, 0, 0, 3, 3'b100, 3'b111, 3, 2, 2'b11, 8'hE6, 8'h12, 8'h88, 8'h12, 0, 0);
    vecs[7]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000, 3'b111, 3, 3, 2'b11, 8'h00, 8'h01, 8'h88, 8'h88, 0, 0);
    vecs[8]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000, 3'b111, 3, 1, 2'b11, 8'h02, 8'h03, 8'h02, 8'h03, 0, 0);
    vecs[9]  = mk(8'hEE, 8'h00, 8'hFF, 0, 0, 0, 3'b101, 3'b111, 0, 0, 2'b11, 8'hF0, 8'hF1, 8'hEE, 8'hEE, 0, 0);
    vecs[10] = mk(8'h00, 8'h5C, 8'h00, 0, 0, 0, 3'b010, 3'b111, 0, 2, 2'b11, 8'hF2, 8'h21, 8'h5C, 8'h21, 0, 0);
    vecs[11] = mk(8'h00, 8'h00, 8'h99, 0, 0, 2, 3'b100, 3'b011, 2, 1, 2'b11, 8'hF3, 8'h31, 8'h99, 8'h31, 1, 1);
    vecs[12] = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 3'b000, 3'b111, 1, 3, 2'b11, 8'h41, 8'h42, 8'h41, 8'h42, 0, 0);

    // Reset: hazard present but stall held low, forwarding still active.
    rst_n = 1'b0;
    quiet();
    src_we = 3'b001; src_addr[1:0] = 2'd1; src_data[7:0] = 8'h3E; src_ready = 3'b110;
    rd_en = 2'b01; rd_addr[1:0] = 2'd1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_fw0", 32'(fw_data[7:0]), 32'h3E);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, one cycle each.
    for (int i = 0; i < 13; i++) begin
      quiet();
      src_data  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      src_addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      src_we    = vecs[i].we;
      src_ready = vecs[i].rdy;
      rd_addr   = {vecs[i].p1, vecs[i].p0};
      rd_en     = vecs[i].en;
      rd_data   = {vecs[i].rf1, vecs[i].rf0};
      #1;
      chk($sformatf("v%0d_fw0", i), 32'(fw_data[7:0]), 32'(vecs[i].f0));
      chk($sformatf("v%0d_fw1", i), 32'(fw_data[15:8]), 32'(vecs[i].f1));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].st));
      chk($sformatf("v%0d_bubble", i), 32'(bubble), 32'(vecs[i].bb));
      @(negedge clk);
    end

    // WB write then hold-entry forwarding for exactly one cycle.
    quiet();
    src_we = 3'b100; src_addr[5:4] = 2'd2; src_data[23:16] = 8'h5A;
    rd_en = 2'b10; rd_addr[3:2] = 2'd2;
    #1 chk("wb_direct", 32'(fw_data[15:8]), 32'h5A);
    @(negedge clk);
    quiet(); rd_en = 2'b10; rd_addr[3:2] = 2'd2; rd_data[15:8] = 8'h00;
    #1 chk("hold_n1", 32'(fw_data[15:8]), 32'h5A);
    @(negedge clk);
    quiet(); rd_en = 2'b10; rd_addr[3:2] = 2'd2; rd_data[15:8] = 8'h3C;
    #1 chk("hold_n2", 32'(fw_data[15:8]), 32'h3C);
    @(negedge clk);

    // Load-use stall for one cycle.
    quiet(); cnt_clr = 1'b1;
    @(negedge clk);
    quiet();
    src_we = 3'b001; src_addr[1:0] = 2'd3; src_ready = 3'b110;
    rd_en = 2'b01; rd_addr[1:0] = 2'd3;
    #1;
    chk("lu_cnt0", 32'(stall_cnt), 32'h0);
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_bubble", 32'(bubble), 32'h1);
    @(negedge clk);
    quiet();
    #1;
    chk("lu_stall_after", 32'(stall), 32'h0);
    chk("lu_cnt1", 32'(stall_cnt), 32'h1);
    @(negedge clk);

    // mem_busy for 4 cycles; hold entry frozen across MEM_WAIT.
    quiet(); cnt_clr = 1'b1;
    @(negedge clk);
    quiet(); mem_busy = 1'b1;
    src_we = 3'b100; src_addr[5:4] = 2'd1; src_data[23:16] = 8'hD1;
    #1 chk("mw_c0_stall", 32'(stall), 32'h0);
    @(negedge clk);
    quiet(); mem_busy = 1'b1; rd_en = 2'b10; rd_addr[3:2] = 2'd1;
    #1;
    chk("mw_c1_stall", 32'(stall), 32'h1);
    chk("mw_c1_bubble", 32'(bubble), 32'h0);
    chk("mw_c1_hold", 32'(fw_data[15:8]), 32'hD1);
    @(negedge clk);
    quiet(); mem_busy = 1'b1;
    src_we = 3'b101; src_addr = {2'd1, 2'd0, 2'd2}; src_data = {8'hE2, 8'h00, 8'h4D};
    src_ready = 3'b110; rd_en = 2'b11; rd_addr = {2'd1, 2'd2};
    #1;
    chk("mw_c2_stall", 32'(stall), 32'h1);
    chk("mw_c2_bubble", 32'(bubble), 32'h0);
    chk("mw_c2_fw0", 32'(fw_data[7:0]), 32'h4D);
    chk("mw_c2_fw1", 32'(fw_data[15:8]), 32'hE2);
    @(negedge clk);
    quiet(); mem_busy = 1'b1; rd_en = 2'b10; rd_addr[3:2] = 2'd1;
    #1 chk("mw_c3_hold", 32'(fw_data[15:8]), 32'hD1);
    @(negedge clk);
    quiet(); rd_en = 2'b10; rd_addr[3:2] = 2'd1;
    #1;
    chk("mw_c4_stall", 32'(stall), 32'h1);
    chk("mw_c4_hold", 32'(fw_data[15:8]), 32'hD1);
    @(negedge clk);
    quiet(); rd_en = 2'b10; rd_addr[3:2] = 2'd1;
    #1;
    chk("mw_c5_stall", 32'(stall), 32'h0);
    chk("mw_c5_cnt", 32'(stall_cnt), 32'h4);
    chk("mw_c5_hold", 32'(fw_data[15:8]), 32'hD1);
    @(negedge clk);
    quiet(); rd_en = 2'b10; rd_addr[3:2] = 2'd1; rd_data[15:8] = 8'h6B;
    #1 chk("mw_c6_expired", 32'(fw_data[15:8]), 32'h6B);
    @(negedge clk);

    // Zero register never forwards or stalls when ZERO_REG=1.
    quiet(); src_we = 3'b001; src_data[7:0] = 8'hFF; rd_en = 2'b01;
    #1;
    chk("zr_fw0", 32'(z_fw_data[7:0]), 32'h00);
    chk("nz_fw0", 32'(fw_data[7:0]), 32'hFF);
    @(negedge clk);
    quiet(); src_we = 3'b001; src_data[7:0] = 8'hFF; src_ready = 3'b110; rd_en = 2'b01;
    #1;
    chk("zr_stall", 32'(z_stall), 32'h0);
    chk("zr_fw0_nr", 32'(z_fw_data[7:0]), 32'h00);
    chk("nz_stall", 32'(stall), 32'h1);
    @(negedge clk);

    // Reset asserted during MEM_WAIT.
    quiet(); mem_busy = 1'b1;
    @(negedge clk);
    quiet(); mem_busy = 1'b1;
    #1 chk("rm_pre_stall", 32'(stall), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_stall", 32'(stall), 32'h0);
    chk("rm_bubble", 32'(bubble), 32'h0);
    chk("rm_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rm_post_idle", 32'(stall), 32'h0);
    @(negedge clk);
    quiet();
    #1 chk("rm_post_wait", 32'(stall), 32'h1);
    @(negedge clk);
    #1 chk("rm_post_back", 32'(stall), 32'h0);
    @(negedge clk);

    // Counter saturation (3-bit instance) and clear overriding increment.
    quiet(); cnt_clr = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      quiet(); mem_busy = 1'b1;
      @(negedge clk);
    end
    quiet(); mem_busy = 1'b1; cnt_clr = 1'b1;
    #1;
    chk("sat_cnt3", 32'(s_stall_cnt), 32'h7);
    chk("sat_cnt16", 32'(stall_cnt), 32'd10);
    @(negedge clk);
    quiet();
    #1;
    chk("clr_stall", 32'(stall), 32'h1);
    chk("clr_cnt16", 32'(stall_cnt), 32'h0);
    chk("clr_cnt3", 32'(s_stall_cnt), 32'h0);
    @(negedge clk);
    quiet();
    #1;
    chk("inc_cnt16", 32'(stall_cnt), 32'h1);
    chk("inc_cnt3", 32'(s_stall_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL take parameters, one per line:
  DATA_W, 8, datapath width
  ADDR_W, 2, register address width
  NUM_RD, 2, register read ports
  NUM_SRC, 3, forward sources (index 0 = youngest/EX, NUM_SRC-1 = oldest/WB)
  ZERO_REG, 0, 1 = register 0 reads zero and never forwards
  CNT_W, 16, stall counter width
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  src_data  in  NUM_SRC*DATA_W  per-source write data
  src_addr  in  NUM_SRC*ADDR_W  per-source destination register
  src_we  in  NUM_SRC  per-source write enable
  src_ready  in  NUM_SRC  source data valid this cycle (0 = load in flight)
  rd_addr  in  NUM_RD*ADDR_W  ID read addresses
  rd_en  in  NUM_RD  read port in use
  rd_data  in  NUM_RD*DATA_W  register file read data
  mem_busy  in  1  data memory multi-cycle access pending
  cnt_clr  in  1  synchronous stall counter clear
  fw_data  out  NUM_RD*DATA_W  forwarded operands to EX
  stall  out  1  freeze PC and IF/ID
  bubble  out  1  inject NOP into EX
  stall_cnt  out  CNT_W  cycles with stall=1
REQ-003 SHALL use one clock clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 Per read port: match[s] = src_we[s] & (rd_addr == src_addr[s]); winner = lowest-index matching source (youngest wins).
REQ-005 fw_data SHALL be winner's src_data; if no source match, hold-entry data if it matches (REQ-007); else rd_data.
REQ-006 ZERO_REG=1 and rd_addr=0: fw_data SHALL be 0 regardless of matches.
REQ-007 Hold entry: registered copy of source NUM_SRC-1 (addr, data) captured when its src_we=1; valid for exactly the next cycle; lowest forwarding priority.
REQ-008 Load-use hazard: any port with rd_en=1 whose winner has src_ready=0 SHALL raise stall=1 and bubble=1 combinationally in that cycle; not-ready older matches shadowed by a younger ready match SHALL NOT stall.
REQ-009 FSM states IDLE, MEM_WAIT; IDLE->MEM_WAIT when mem_busy=1; MEM_WAIT->IDLE when mem_busy=0.
REQ-010 In MEM_WAIT: stall=1, bubble=0, load-use detection suppressed; hold entry SHALL NOT update or expire.
REQ-011 mem_busy=1 and load-use hazard in the same IDLE cycle: stall=1, bubble=1 that cycle, then MEM_WAIT.
REQ-012 stall_cnt SHALL increment each cycle stall=1, saturate at all-ones, no wrap.
REQ-013 cnt_clr=1 SHALL zero stall_cnt next edge, overriding same-cycle increment.
REQ-014 Forwarding path SHALL be zero-latency combinational; only FSM, hold entry, counter are registered.

Reset
REQ-015 rst_n low SHALL asynchronously set state=IDLE, hold valid=0, hold addr/data=0, stall_cnt=0.
REQ-016 While rst_n low, stall=0 and bubble=0; fw_data follows REQ-005 with hold invalid.
REQ-017 Reset mid-MEM_WAIT SHALL return to IDLE; first post-reset cycle evaluates from IDLE.

Structure
REQ-018 Shared package hazard_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-019 Per-port priority select SHALL be one sub-module fwd_port_mux, instantiated NUM_RD times by generate.

Verification
REQ-020 Bench SHALL cover (defaults):
  EX and DM both write r1 (0x11, 0x22), port0 reads r1 -> fw_data0=0x11, stall=0.
  WB writes r2=0x5A at cycle n, none next cycle, port1 reads r2 at n+1 with rd_data=0x00 -> fw_data1=0x5A; at n+2 -> rd_data.
  EX load to r3 with src_ready=0, port0 reads r3 -> stall=1, bubble=1 one cycle; stall_cnt=1.
  mem_busy high 4 cycles -> stall=1 4 cycles, bubble=0, stall_cnt+=4; IDLE after.
  ZERO_REG=1, EX writes r0=0xFF, port0 reads r0 -> fw_data0=0x00.
  rst_n low during MEM_WAIT -> stall=0 immediately, stall_cnt=0, IDLE after release.
